bp_be_rpt_assoc: RTL

- Parametrised, N-way set-associative Reference Prediction Table (RPT) for the BE load path.
- Trains on (load PC, effective address) pairs and tracks a signed stride per load with a confidence counter.
- When a load is confidently striding, issues a burst of prefetch addresses over a valid/yumi handshake.
- Successor of the 2-way RPT: generalised ways, counter width, threshold and prefetch degree; adds tree-PLRU replacement, same-set forwarding, signed stride range checking and prefetch generation.

---
 rtl/bp_be_rpt_assoc.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_be_rpt_assoc.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_rpt_assoc
// Brief    : N-way set-associative reference prediction table. Learns a
//            signed stride per load PC with a confidence counter and issues
//            prefetch bursts over a valid/yumi handshake.
//            Optional statistics counters: define BP_BE_RPT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_rpt_assoc #(
    parameter int vaddr_width_p  = 39,
    parameter int sets_p         = 32,
    parameter int ways_p         = 4,
    parameter int stride_width_p = 12,
    parameter int ctr_width_p    = 2,
    parameter int conf_thresh_p  = 2,
    parameter int pf_degree_p    = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    output logic                      init_done_o,
    input  logic                      train_v_i,
    input  logic [vaddr_width_p-1:0]  train_pc_i,
    input  logic [vaddr_width_p-1:0]  train_eff_addr_i,
    output logic                      res_v_o,
    output logic                      res_hit_o,
    output logic                      res_conf_o,
    output logic [stride_width_p-1:0] res_stride_o,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_yumi_i
`ifdef BP_BE_RPT_STATS_EN
    ,
    output logic [31:0]               stat_train_o,
    output logic [31:0]               stat_hit_o,
    output logic [31:0]               stat_pf_issued_o,
    output logic [31:0]               stat_pf_drop_o
`endif
);

    localparam int idx_width_lp = $clog2(sets_p);
    localparam int tag_width_lp = vaddr_width_p - 1 - idx_width_lp;
    localparam int c_way_w      = $clog2(ways_p);
    localparam int c_cnt_w      = $clog2(pf_degree_p + 1);

    localparam logic [1:0] c_e_reset = 2'd0;
    localparam logic [1:0] c_e_clear = 2'd1;
    localparam logic [1:0] c_e_run   = 2'd2;

    typedef struct packed {
        logic                      valid;
        logic [tag_width_lp-1:0]   tag;
        logic [vaddr_width_p-1:0]  last_addr;
        logic [stride_width_p-1:0] stride;
        logic [ctr_width_p-1:0]    ctr;
    } entry_t;

    typedef struct packed {
        entry_t [ways_p-1:0] way;
        logic   [ways_p-2:0] plru;
    } row_t;

    row_t r_mem [sets_p];

    logic [1:0]              r_state, w_state_nxt;
    logic [idx_width_lp-1:0] r_clr_idx, w_clr_idx_nxt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= c_e_reset;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            c_e_reset: begin
                w_state_nxt   = c_e_clear;
                w_clr_idx_nxt = '0;
            end
            c_e_clear: begin
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == idx_width_lp'(sets_p - 1))
                    w_state_nxt = c_e_run;
            end
            c_e_run: ;
            default: w_state_nxt = c_e_reset;
        endcase
    end

    assign init_done_o = (r_state == c_e_run);

    // Stage 1: accept and read the set (forwarding the row stage 2 is writing)
    logic                    w_accept;
    logic [idx_width_lp-1:0] w_idx;
    logic [tag_width_lp-1:0] w_tag;
    logic                    w_unused;
    row_t                    w_rd_row, w_wr_row;

    logic                     r_s2_v;
    logic [idx_width_lp-1:0]  r_s2_idx;
    logic [tag_width_lp-1:0]  r_s2_tag;
    logic [vaddr_width_p-1:0] r_s2_eff;
    row_t                     r_s2_row;

    assign w_accept = train_v_i && (r_state == c_e_run);
    assign w_idx    = train_pc_i[idx_width_lp:1];
    assign w_tag    = train_pc_i[vaddr_width_p-1:idx_width_lp+1];
    assign w_unused = train_pc_i[0];
    assign w_rd_row = (r_s2_v && (r_s2_idx == w_idx)) ? w_wr_row : r_mem[w_idx];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_s2_v <= 1'b0;
        else            r_s2_v <= w_accept;
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_s2_idx <= w_idx;
            r_s2_tag <= w_tag;
            r_s2_eff <= train_eff_addr_i;
            r_s2_row <= w_rd_row;
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_state == c_e_clear) r_mem[r_clr_idx] <= '0;
        else if (r_s2_v)          r_mem[r_s2_idx]  <= w_wr_row;
    end

    // Stage 2: compare, select way, update entry and PLRU
    logic                     w_hit, w_has_inv, w_in_range, w_conf, w_dir;
    logic [c_way_w-1:0]       w_hit_way, w_inv_way, w_plru_way, w_vic_way;
    logic [c_way_w-1:0]       w_node, w_way_sh;
    logic [vaddr_width_p-1:0] w_diff;
    logic [ways_p-2:0]        w_plru_new;
    entry_t                   w_old, w_new;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = ways_p - 1; w >= 0; w--) begin
            if (r_s2_row.way[w].valid && (r_s2_row.way[w].tag == r_s2_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_way_w'(w);
            end
            if (!r_s2_row.way[w].valid) begin
                w_has_inv = 1'b1;
                w_inv_way = c_way_w'(w);
            end
        end

        // Each PLRU bit points toward the less recently used subtree
        w_node     = '0;
        w_plru_way = '0;
        for (int l = 0; l < c_way_w; l++) begin
            w_plru_way = (w_plru_way << 1) | c_way_w'(r_s2_row.plru[w_node]);
            w_node     = (w_node << 1) + c_way_w'(1) + c_way_w'(r_s2_row.plru[w_node]);
        end

        w_vic_way = w_hit ? w_hit_way : (w_has_inv ? w_inv_way : w_plru_way);

        w_old      = r_s2_row.way[w_vic_way];
        w_diff     = r_s2_eff - w_old.last_addr;
        w_in_range = (&w_diff[vaddr_width_p-1:stride_width_p-1]) ||
                     !(|w_diff[vaddr_width_p-1:stride_width_p-1]);
        w_new      = w_old;
        if (w_hit) begin
            w_new.last_addr = r_s2_eff;
            if (w_in_range && (w_diff[stride_width_p-1:0] == w_old.stride)) begin
                if (w_old.ctr != '1) w_new.ctr = w_old.ctr + 1'b1;
            end else if (w_old.ctr != '0) begin
                w_new.ctr = w_old.ctr - 1'b1;
            end else begin
                w_new.stride = w_in_range ? w_diff[stride_width_p-1:0] : '0;
            end
        end else begin
            w_new.valid     = 1'b1;
            w_new.tag       = r_s2_tag;
            w_new.last_addr = r_s2_eff;
            w_new.stride    = '0;
            w_new.ctr       = '0;
        end

        w_plru_new = r_s2_row.plru;
        w_node     = '0;
        w_way_sh   = w_vic_way;
        w_dir      = 1'b0;
        for (int l = 0; l < c_way_w; l++) begin
            w_dir              = w_way_sh[c_way_w-1];
            w_plru_new[w_node] = ~w_dir;
            w_node             = (w_node << 1) + c_way_w'(1) + c_way_w'(w_dir);
            w_way_sh           = w_way_sh << 1;
        end

        w_wr_row                = r_s2_row;
        w_wr_row.way[w_vic_way] = w_new;
        w_wr_row.plru           = w_plru_new;

        w_conf = (w_new.ctr >= ctr_width_p'(conf_thresh_p));
    end

    logic r_res_v, r_res_hit, r_res_conf;
    logic [stride_width_p-1:0] r_res_stride;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_res_v      <= 1'b0;
            r_res_hit    <= 1'b0;
            r_res_conf   <= 1'b0;
            r_res_stride <= '0;
        end else begin
            r_res_v <= r_s2_v;
            if (r_s2_v) begin
                r_res_hit    <= w_hit;
                r_res_conf   <= w_conf;
                r_res_stride <= w_new.stride;
            end
        end
    end

    assign res_v_o      = r_res_v;
    assign res_hit_o    = r_res_hit;
    assign res_conf_o   = r_res_conf;
    assign res_stride_o = r_res_stride;

    // Prefetch burst generator
    logic                     w_conf_hit, w_pf_fire, w_pf_last, w_pf_load, w_pf_drop;
    logic [vaddr_width_p-1:0] w_sext_stride;
    logic                     r_pf_v;
    logic [vaddr_width_p-1:0] r_pf_addr, r_pf_stride;
    logic [c_cnt_w-1:0]       r_pf_cnt;

    assign w_sext_stride = {{(vaddr_width_p-stride_width_p){w_new.stride[stride_width_p-1]}},
                            w_new.stride};
    assign w_conf_hit = r_s2_v && w_hit && w_conf && (w_new.stride != '0);
    assign w_pf_fire  = r_pf_v && pf_yumi_i;
    assign w_pf_last  = (r_pf_cnt == c_cnt_w'(pf_degree_p - 1));
    assign w_pf_load  = w_conf_hit && (!r_pf_v || (w_pf_fire && w_pf_last));
    assign w_pf_drop  = w_conf_hit && !w_pf_load;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pf_v      <= 1'b0;
            r_pf_addr   <= '0;
            r_pf_stride <= '0;
            r_pf_cnt    <= '0;
        end else if (w_pf_load) begin
            r_pf_v      <= 1'b1;
            r_pf_addr   <= r_s2_eff + w_sext_stride;
            r_pf_stride <= w_sext_stride;
            r_pf_cnt    <= '0;
        end else if (w_pf_fire) begin
            if (w_pf_last) begin
                r_pf_v <= 1'b0;
            end else begin
                r_pf_addr <= r_pf_addr + r_pf_stride;
                r_pf_cnt  <= r_pf_cnt + 1'b1;
            end
        end
    end

    assign pf_v_o    = r_pf_v;
    assign pf_addr_o = r_pf_addr;

`ifdef BP_BE_RPT_STATS_EN
    logic [31:0] r_stat_train, r_stat_hit, r_stat_pf_issued, r_stat_pf_drop;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stat_train     <= '0;
            r_stat_hit       <= '0;
            r_stat_pf_issued <= '0;
            r_stat_pf_drop   <= '0;
        end else begin
            if (w_accept && (r_stat_train != '1))         r_stat_train     <= r_stat_train + 1'b1;
            if (r_s2_v && w_hit && (r_stat_hit != '1))    r_stat_hit       <= r_stat_hit + 1'b1;
            if (w_pf_fire && (r_stat_pf_issued != '1))    r_stat_pf_issued <= r_stat_pf_issued + 1'b1;
            if (w_pf_drop && (r_stat_pf_drop != '1))      r_stat_pf_drop   <= r_stat_pf_drop + 1'b1;
        end
    end

    assign stat_train_o     = r_stat_train;
    assign stat_hit_o       = r_stat_hit;
    assign stat_pf_issued_o = r_stat_pf_issued;
    assign stat_pf_drop_o   = r_stat_pf_drop;
`endif

endmodule
`default_nettype wire
